// File: rtl/types_pkg.sv
// Shared payload types for the model/triangle transform path.
package types_pkg;

    localparam int unsigned MODEL_ADDR_W = 12;
    localparam int unsigned MODEL_CNT_W  = 12;
    localparam int unsigned COORD_W      = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] sz;
        logic [COORD_W-1:0] tx;
        logic [COORD_W-1:0] ty;
        logic [COORD_W-1:0] tz;
    } transform_t;

    typedef struct packed {
        triangle_t  triangle;
        transform_t transform;
    } triangle_tf_t;

    typedef struct packed {
        transform_t              transform;
        logic [MODEL_ADDR_W-1:0] base;
        logic [MODEL_CNT_W-1:0]  count;
        logic                    last_model;
    } model_cmd_t;

    typedef struct packed {
        triangle_t triangle;
        logic      last;
    } fifo_entry_t;

endpackage

// File: rtl/tf_out_fifo.sv
// Two-entry shift FIFO for returned triangles; head and tail are plain registers.
module tf_out_fifo
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count,
    output logic        valid
);

    fifo_entry_t tail;
    logic [1:0]  count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // On pop the tail shifts into the head; a simultaneous push lands behind it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
            valid <= 1'b0;
        end else begin
            count <= count_next;
            valid <= (count_next != 2'd0);
            if (pop) begin
                if (push && count == 2'd1) begin
                    head <= push_data;
                end else begin
                    head <= tail;
                end
                if (push && count == 2'd2) begin
                    tail <= push_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= push_data;
                end else begin
                    tail <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/model_tf_sequencer.sv
// Streams each model's triangles, paired with its transform, into Transform.
// Optional perf counters are enabled by defining MODEL_TF_SEQ_PERF_EN.
module model_tf_sequencer
    import types_pkg::*;
#(
    parameter int unsigned ADDR_W = MODEL_ADDR_W,
    parameter int unsigned CNT_W  = MODEL_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  model_cmd_t        cmd_s_data,
    input  logic              cmd_s_valid,
    output logic              cmd_s_ready,
    output logic              tri_rd_en,
    output logic [ADDR_W-1:0] tri_rd_addr,
    input  triangle_t         tri_rd_data,
    output triangle_tf_t      triangle_tf_m_data,
    output logic              triangle_tf_m_metadata,
    output logic              triangle_tf_m_valid,
    input  logic              triangle_tf_m_ready,
`ifdef MODEL_TF_SEQ_PERF_EN
    output logic [31:0]       perf_tri_count,
    output logic [31:0]       perf_stall_count,
`endif
    output logic              frame_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_next;
    transform_t         tf_q;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   issued_q;
    logic               last_model_q;
    logic               inflight_q;
    logic               inflight_last_q;
    logic [1:0]         fifo_count;
    logic               fifo_valid;
    fifo_entry_t        fifo_head;
    logic               pop;
    logic               cmd_fire;
    logic               credit;
    logic               rd_last;
    logic [2:0]         occ;

    assign pop      = fifo_valid & triangle_tf_m_ready;
    assign cmd_fire = cmd_s_valid & cmd_s_ready;
    // pop implies a non-empty FIFO, so occ never underflows.
    assign occ      = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign credit   = (occ < 3'd2);
    assign rd_last  = last_model_q & (issued_q == count_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_s_ready = 1'b0;
        tri_rd_en   = 1'b0;
        tri_rd_addr = '0;
        case (state)
            IDLE: begin
                cmd_s_ready = 1'b1;
                if (cmd_s_valid && cmd_s_data.count != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    tri_rd_en   = 1'b1;
                    tri_rd_addr = base_q + ADDR_W'(issued_q);
                    if (issued_q + CNT_W'(1) == count_q) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final pop empties the FIFO.
                if (fifo_count == 2'(pop) && !inflight_q) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tf_q            <= '0;
            base_q          <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            last_model_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            if (cmd_fire) begin
                tf_q         <= cmd_s_data.transform;
                base_q       <= ADDR_W'(cmd_s_data.base);
                count_q      <= CNT_W'(cmd_s_data.count);
                last_model_q <= cmd_s_data.last_model;
                issued_q     <= '0;
            end else if (tri_rd_en) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            inflight_q      <= tri_rd_en;
            inflight_last_q <= tri_rd_en & rd_last;
            frame_done      <= (pop & fifo_head.last)
                             | (cmd_fire & (cmd_s_data.count == '0) & cmd_s_data.last_model);
        end
    end

    tf_out_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data ({tri_rd_data, inflight_last_q}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .valid     (fifo_valid)
    );

    assign triangle_tf_m_data     = {fifo_head.triangle, tf_q};
    assign triangle_tf_m_metadata = fifo_head.last;
    assign triangle_tf_m_valid    = fifo_valid;

`ifdef MODEL_TF_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_tri_count   <= '0;
            perf_stall_count <= '0;
        end else if (frame_done) begin
            perf_tri_count   <= '0;
            perf_stall_count <= '0;
        end else begin
            if (pop && perf_tri_count != '1) begin
                perf_tri_count <= perf_tri_count + 32'd1;
            end
            if (fifo_valid && !triangle_tf_m_ready && perf_stall_count != '1) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_model_tf_sequencer.sv
// Directed bench for model_tf_sequencer with a one-cycle-latency triangle memory model.
module tb_model_tf_sequencer;
    import types_pkg::*;

    typedef struct {
        triangle_t  tg;
        transform_t tf;
        logic       meta;
        int         cyc;
    } out_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    model_cmd_t   cmd_s_data = '0;
    logic         cmd_s_valid = 1'b0;
    logic         cmd_s_ready;
    logic         tri_rd_en;
    logic [11:0]  tri_rd_addr;
    triangle_t    tri_rd_data = '0;
    triangle_tf_t triangle_tf_m_data;
    logic         triangle_tf_m_metadata;
    logic         triangle_tf_m_valid;
    logic         triangle_tf_m_ready = 1'b0;
    logic         frame_done;

    int total = 0;
    int bad = 0;

    out_t outs[$];
    int   rd_addr[$];
    int   rd_cyc[$];
    int   acc_cyc, acc2_cyc, fd_cyc, fd_n, stall_bad, max_out;

    always #5 clk = ~clk;

    model_tf_sequencer dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .cmd_s_data             (cmd_s_data),
        .cmd_s_valid            (cmd_s_valid),
        .cmd_s_ready            (cmd_s_ready),
        .tri_rd_en              (tri_rd_en),
        .tri_rd_addr            (tri_rd_addr),
        .tri_rd_data            (tri_rd_data),
        .triangle_tf_m_data     (triangle_tf_m_data),
        .triangle_tf_m_metadata (triangle_tf_m_metadata),
        .triangle_tf_m_valid    (triangle_tf_m_valid),
        .triangle_tf_m_ready    (triangle_tf_m_ready),
        .frame_done             (frame_done)
    );

    function automatic triangle_t mk_tri(input int a);
        triangle_t t;
        t = '0;
        t.v0.x = 16'(a);
        t.v1.y = 16'(a) ^ 16'h5a5a;
        t.v2.z = ~16'(a);
        return t;
    endfunction

    function automatic transform_t mk_tf(input int k);
        transform_t f;
        f = '0;
        f.sx = 16'(k);
        f.tz = 16'(k * 7 + 1);
        return f;
    endfunction

    function automatic model_cmd_t mk_cmd(input int k, input int base, input int cnt, input logic last);
        model_cmd_t c;
        c.transform  = mk_tf(k);
        c.base       = 12'(base);
        c.count      = 12'(cnt);
        c.last_model = last;
        return c;
    endfunction

    // Triangle memory: data for the read address appears one cycle later.
    always @(posedge clk) begin
        if (tri_rd_en) begin
            tri_rd_data <= mk_tri(int'(tri_rd_addr));
        end
    end

    // Drives one command (optionally a second held behind it) and records what the DUT does.
    task automatic run_cmd(input model_cmd_t c, input model_cmd_t c2, input logic has2,
                           input logic toggle, input int ncyc, input int stop_after);
        int phase = 0;
        int rd = 0;
        int po = 0;
        logic stalled = 1'b0;
        logic hs;
        triangle_tf_t held_d = '0;
        logic held_m = 1'b0;
        outs.delete();
        rd_addr.delete();
        rd_cyc.delete();
        acc_cyc = -1; acc2_cyc = -1; fd_cyc = -1; fd_n = 0; stall_bad = 0; max_out = 0;
        cmd_s_data  = c;
        cmd_s_valid = 1'b1;
        for (int t = 0; t < ncyc; t++) begin
            triangle_tf_m_ready = toggle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            #1;
            if (stalled && (!triangle_tf_m_valid || triangle_tf_m_data !== held_d
                            || triangle_tf_m_metadata !== held_m)) stall_bad++;
            if (tri_rd_en) begin
                rd_addr.push_back(int'(tri_rd_addr));
                rd_cyc.push_back(t);
                rd++;
            end
            if (triangle_tf_m_valid && triangle_tf_m_ready) begin
                outs.push_back('{triangle_tf_m_data.triangle, triangle_tf_m_data.transform,
                                 triangle_tf_m_metadata, t});
                po++;
            end
            if (rd - po > max_out) max_out = rd - po;
            if (frame_done) begin
                fd_n++;
                if (fd_cyc < 0) fd_cyc = t;
            end
            hs = cmd_s_valid && cmd_s_ready;
            if (hs) begin
                if (phase == 0) acc_cyc = t;
                else acc2_cyc = t;
            end
            stalled = triangle_tf_m_valid && !triangle_tf_m_ready;
            held_d  = triangle_tf_m_data;
            held_m  = triangle_tf_m_metadata;
            @(posedge clk); #1;
            if (hs) begin
                if (phase == 0 && has2) begin
                    cmd_s_data = c2;
                    phase = 1;
                end else begin
                    cmd_s_valid = 1'b0;
                    cmd_s_data  = '0;
                end
            end
            if (stop_after > 0 && outs.size() >= stop_after) return;
        end
        cmd_s_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({cmd_s_ready, tri_rd_en, tri_rd_addr, triangle_tf_m_valid, triangle_tf_m_metadata, frame_done}
            !== {1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy=%b en=%b addr=%0d v=%b m=%b fd=%b", cmd_s_ready, tri_rd_en,
                     tri_rd_addr, triangle_tf_m_valid, triangle_tf_m_metadata, frame_done);
        end
        total++;
        if (triangle_tf_m_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", triangle_tf_m_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_cmd(mk_cmd(1, 10, 3, 1'b1), '0, 1'b0, 1'b0, 10, 0);
        total++;
        if (acc_cyc !== 0) begin bad++; $display("FAIL t1_accept: got %0d want 0", acc_cyc); end
        total++;
        if (rd_addr.size() != 3) begin bad++; $display("FAIL t1_nreads: got %0d want 3", rd_addr.size()); end
        for (int i = 0; i < rd_addr.size() && i < 3; i++) begin
            total++;
            if (rd_addr[i] != 10 + i || rd_cyc[i] != 1 + i) begin
                bad++;
                $display("FAIL t1_read[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d",
                         i, rd_addr[i], rd_cyc[i], 10 + i, 1 + i);
            end
        end
        total++;
        if (outs.size() != 3) begin bad++; $display("FAIL t1_nouts: got %0d want 3", outs.size()); end
        for (int i = 0; i < outs.size() && i < 3; i++) begin
            total++;
            if (outs[i].tg !== mk_tri(10 + i) || outs[i].tf !== mk_tf(1)
                || outs[i].meta !== (i == 2) || outs[i].cyc != 3 + i) begin
                bad++;
                $display("FAIL t1_out[%0d]: got tri %h meta %b cyc %0d want tri %h meta %b cyc %0d",
                         i, outs[i].tg, outs[i].meta, outs[i].cyc, mk_tri(10 + i), (i == 2), 3 + i);
            end
        end
        total++;
        if (fd_cyc != 6 || fd_n != 1) begin
            bad++;
            $display("FAIL t1_frame_done: got cyc %0d n %0d want cyc 6 n 1", fd_cyc, fd_n);
        end
    endtask

    task automatic test_backpressure();
        run_cmd(mk_cmd(2, 100, 4, 1'b1), '0, 1'b0, 1'b1, 30, 0);
        total++;
        if (outs.size() != 4) begin bad++; $display("FAIL t2_nouts: got %0d want 4", outs.size()); end
        for (int i = 0; i < outs.size() && i < 4; i++) begin
            total++;
            if (outs[i].tg !== mk_tri(100 + i) || outs[i].meta !== (i == 3)) begin
                bad++;
                $display("FAIL t2_out[%0d]: got tri %h meta %b want tri %h meta %b",
                         i, outs[i].tg, outs[i].meta, mk_tri(100 + i), (i == 3));
            end
        end
        total++;
        if (stall_bad != 0) begin bad++; $display("FAIL t2_stable: got %0d changes want 0", stall_bad); end
        total++;
        if (max_out > 2) begin bad++; $display("FAIL t2_outstanding: got %0d want <=2", max_out); end
        total++;
        if (rd_addr.size() != 4 || fd_n != 1) begin
            bad++;
            $display("FAIL t2_reads_fd: got reads %0d fd %0d want 4 1", rd_addr.size(), fd_n);
        end
    endtask

    task automatic test_empty_model();
        run_cmd(mk_cmd(3, 50, 0, 1'b1), '0, 1'b0, 1'b0, 4, 0);
        total++;
        if (rd_addr.size() != 0 || outs.size() != 0 || fd_cyc != 1 || fd_n != 1) begin
            bad++;
            $display("FAIL t3_empty_last: got reads %0d outs %0d fd_cyc %0d fd_n %0d want 0 0 1 1",
                     rd_addr.size(), outs.size(), fd_cyc, fd_n);
        end
        run_cmd(mk_cmd(4, 50, 0, 1'b0), '0, 1'b0, 1'b0, 4, 0);
        total++;
        if (acc_cyc != 0 || rd_addr.size() != 0 || outs.size() != 0 || fd_n != 0) begin
            bad++;
            $display("FAIL t3_empty_discard: got acc %0d reads %0d outs %0d fd_n %0d want 0 0 0 0",
                     acc_cyc, rd_addr.size(), outs.size(), fd_n);
        end
    endtask

    task automatic test_back_to_back();
        int exp_a[3] = '{200, 201, 300};
        int exp_c[3] = '{3, 4, 8};
        run_cmd(mk_cmd(5, 200, 2, 1'b0), mk_cmd(6, 300, 1, 1'b1), 1'b1, 1'b0, 14, 0);
        total++;
        if (acc_cyc != 0 || acc2_cyc != 5) begin
            bad++;
            $display("FAIL t4_accept: got A %0d B %0d want 0 5", acc_cyc, acc2_cyc);
        end
        total++;
        if (outs.size() != 3) begin bad++; $display("FAIL t4_nouts: got %0d want 3", outs.size()); end
        for (int i = 0; i < outs.size() && i < 3; i++) begin
            total++;
            if (outs[i].tg !== mk_tri(exp_a[i]) || outs[i].tf !== mk_tf(i < 2 ? 5 : 6)
                || outs[i].meta !== (i == 2) || outs[i].cyc != exp_c[i]) begin
                bad++;
                $display("FAIL t4_out[%0d]: got tri %h tf %h meta %b cyc %0d want tri %h tf %h meta %b cyc %0d",
                         i, outs[i].tg, outs[i].tf, outs[i].meta, outs[i].cyc,
                         mk_tri(exp_a[i]), mk_tf(i < 2 ? 5 : 6), (i == 2), exp_c[i]);
            end
        end
        total++;
        if (fd_cyc != 9 || fd_n != 1) begin
            bad++;
            $display("FAIL t4_frame_done: got cyc %0d n %0d want 9 1", fd_cyc, fd_n);
        end
    endtask

    task automatic test_addr_wrap();
        int exp_a[3] = '{4094, 4095, 0};
        run_cmd(mk_cmd(7, 4094, 3, 1'b1), '0, 1'b0, 1'b0, 10, 0);
        total++;
        if (rd_addr.size() != 3 || outs.size() != 3) begin
            bad++;
            $display("FAIL t5_counts: got reads %0d outs %0d want 3 3", rd_addr.size(), outs.size());
        end
        for (int i = 0; i < rd_addr.size() && i < 3; i++) begin
            total++;
            if (rd_addr[i] != exp_a[i]) begin
                bad++;
                $display("FAIL t5_addr[%0d]: got %0d want %0d", i, rd_addr[i], exp_a[i]);
            end
        end
        for (int i = 0; i < outs.size() && i < 3; i++) begin
            total++;
            if (outs[i].tg !== mk_tri(exp_a[i])) begin
                bad++;
                $display("FAIL t5_out[%0d]: got %h want %h", i, outs[i].tg, mk_tri(exp_a[i]));
            end
        end
    endtask

    task automatic test_reset_abort();
        run_cmd(mk_cmd(8, 500, 5, 1'b1), '0, 1'b0, 1'b0, 12, 2);
        total++;
        if (outs.size() != 2) begin bad++; $display("FAIL t6_pre_outs: got %0d want 2", outs.size()); end
        rstn = 1'b0;
        #1;
        total++;
        if ({cmd_s_ready, tri_rd_en, tri_rd_addr, triangle_tf_m_valid, triangle_tf_m_metadata, frame_done}
            !== {1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0} || triangle_tf_m_data !== '0) begin
            bad++;
            $display("FAIL t6_reset_vals: got rdy=%b en=%b addr=%0d v=%b m=%b fd=%b data=%h", cmd_s_ready,
                     tri_rd_en, tri_rd_addr, triangle_tf_m_valid, triangle_tf_m_metadata, frame_done,
                     triangle_tf_m_data);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({triangle_tf_m_valid, tri_rd_en, frame_done} !== 3'b000) begin
                bad++;
                $display("FAIL t6_quiet[%0d]: got v=%b en=%b fd=%b want 000", i,
                         triangle_tf_m_valid, tri_rd_en, frame_done);
            end
            @(posedge clk); #1;
        end
        run_cmd(mk_cmd(9, 600, 2, 1'b1), '0, 1'b0, 1'b0, 10, 0);
        total++;
        if (rd_addr.size() != 2 || rd_addr[0] != 600 || rd_addr[1] != 601 || rd_cyc[0] != 1) begin
            bad++;
            $display("FAIL t6_restart_reads: got n %0d first %0d at %0d want 2 600 at 1",
                     rd_addr.size(), rd_addr[0], rd_cyc[0]);
        end
        total++;
        if (outs.size() != 2 || outs[0].tg !== mk_tri(600) || outs[1].tg !== mk_tri(601)
            || outs[0].meta !== 1'b0 || outs[1].meta !== 1'b1 || outs[1].tf !== mk_tf(9)) begin
            bad++;
            $display("FAIL t6_restart_outs: got n %0d first %h meta %b,%b", outs.size(), outs[0].tg,
                     outs[0].meta, outs[1].meta);
        end
        total++;
        if (fd_n != 1 || fd_cyc != 5) begin
            bad++;
            $display("FAIL t6_restart_fd: got n %0d cyc %0d want 1 5", fd_n, fd_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_model();
        test_back_to_back();
        test_addr_wrap();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
